// File: rtl/key_decoder_multi.sv
// key_decoder_multi: maps received UART bytes onto NUM_KEYS logical keys via a
// configurable byte table. Each key gets a stretched hold level and a one-cycle
// press pulse. A last-key index strobe and an unmapped-byte strobe are also
// produced for the game FSM and menu logic.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   uart_data      received byte, qualified by uart_valid
//   uart_valid     one-cycle strobe, byte valid
//   key_hold       per-key stretched level (HOLD_CYCLES cycles after last match)
//   key_press      per-key one-cycle pulse
//   last_key_idx   index of most recently matched key
//   last_key_valid one-cycle strobe accompanying an update of last_key_idx
//   unknown_byte   one-cycle strobe, valid byte matched no key
module key_decoder_multi #(
  parameter int unsigned           NUM_KEYS     = 6,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES    = {8'h20, 8'h0D, 8'h64, 8'h61, 8'h73, 8'h77},
  parameter int unsigned           HOLD_CYCLES  = 5000,
  parameter int unsigned           CNT_W        = 16,
  parameter bit                    CASE_FOLD    = 1'b1,
  parameter bit                    REPEAT_PULSE = 1'b0,
  parameter int unsigned           IDX_W        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          uart_data,
  input  logic                uart_valid,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [IDX_W-1:0]    last_key_idx,
  output logic                last_key_valid,
  output logic                unknown_byte
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  // Reject a hold length the counter cannot represent.
  if (64'(HOLD_CYCLES) >= (64'd1 << CNT_W)) begin : g_hold_range_err
    $error("key_decoder_multi: HOLD_CYCLES must be < 2**CNT_W");
  end

  logic [CNT_W-1:0]    cnt      [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_next [NUM_KEYS];
  logic [7:0]          folded;
  logic                hit;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_KEYS-1:0] win_oh;
  logic [NUM_KEYS-1:0] hold_next;
  logic [NUM_KEYS-1:0] press_next;

  // Case fold and priority match: scanning downward lets the lowest index win.
  always_comb begin
    folded  = uart_data;
    hit     = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    if (CASE_FOLD && (uart_data >= 8'h41) && (uart_data <= 8'h5A)) begin
      folded = uart_data + 8'h20;
    end
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (uart_valid && (folded == KEY_CODES[i*8 +: 8])) begin
        hit       = 1'b1;
        win_idx   = IDX_W'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Per-key counter next state; hold level is derived from the next count.
  always_comb begin
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      cnt_next[i] = cnt[i];
      if (win_oh[i]) begin
        cnt_next[i] = HOLD_LOAD;
      end else if (cnt[i] != '0) begin
        cnt_next[i] = cnt[i] - CNT_W'(1);
      end
      hold_next[i]  = (cnt_next[i] != '0);
      // key_hold here is the registered level seen during the match cycle.
      press_next[i] = win_oh[i] && (REPEAT_PULSE || !key_hold[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt[i] <= '0;
      end
      key_hold       <= '0;
      key_press      <= '0;
      last_key_idx   <= '0;
      last_key_valid <= 1'b0;
      unknown_byte   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt[i] <= cnt_next[i];
      end
      key_hold       <= hold_next;
      key_press      <= press_next;
      if (hit) begin
        last_key_idx <= win_idx;
      end
      last_key_valid <= hit;
      unknown_byte   <= uart_valid && !hit;
    end
  end

endmodule
